bus_dma_master: RTL
===================

// Module: bus_dma_master
// PURPOSE
//  Bus master for the 2-master/2-slave shared bus. On a start pulse it copies LENGTH
//  32-bit words from SRC to DST one word at a time: read a word, then write it.
//  Plugs into one master port (m0_* or m1_*) of the bus.
//  Slave 0 is mapped at 0x00-0x1F and slave 1 at 0x20-0x3F, so it can move data between slaves.
// PARAMETERS
//  RD_LAT   1   cycles from m_address valid (read) to m_din valid; legal range 1..3
// PORTS
//  clk         in   1   system clock, rising edge
//  reset_n     in   1   asynchronous active-low reset
//  start       in   1   start request; sampled only in IDLE
//  src_addr    in   8   source word address, latched on accepted start
//  dst_addr    in   8   destination word address, latched on accepted start
//  length      in   8   number of words to copy; 0 = no transfer
//  m_grant     in   1   bus grant from the arbiter
//  m_din       in   32  read data returned by the bus
//  m_req       out  1   bus request
//  m_wr        out  1   1 = write, 0 = read
//  m_address   out  8   bus address
//  m_dout      out  32  write data
//  busy        out  1   high from accepted start until DONE exits
//  done        out  1   one-cycle completion pulse
//  word_cnt    out  8   number of words written so far in the current job
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE. All outputs are 0. Latched addresses, length and data reg are 0.
//  Output timing: all outputs are registered or decoded from registered state only (Moore).
//    No combinational path from any input to any output.
//  States: IDLE, REQ, RD, RD_WAIT, WR, DONE.
//  IDLE: m_req=0, m_wr=0, busy=0.
//    - start=1, length!=0: latch src, dst and length; word_cnt=0; go to REQ.
//    - start=1, length==0: go to DONE (done pulse, no bus activity).
//  REQ: m_req=1, m_wr=0. m_grant=1 -> RD. Otherwise stay in REQ, with no timeout.
//  RD: m_address=src+word_cnt (8-bit, wraps mod 256), m_wr=0. Next state is RD_WAIT.
//  RD_WAIT: m_address stays held. Stay RD_LAT cycles.
//    On the last of those cycles, capture m_din into the data reg, then go to WR.
//  WR: m_wr=1, m_address=dst+word_cnt (wraps mod 256), m_dout=data reg. Lasts exactly one cycle.
//    The write commits at the edge that leaves WR. On that edge word_cnt increments.
//    If word_cnt+1==length -> DONE, else -> RD.
//    While the grant is held, m_req stays 1 back-to-back; there is no re-arbitration between words.
//  DONE: m_req=0, m_wr=0, done=1 for one cycle, busy=1. Next state is IDLE.
//    word_cnt holds its final value until the next accepted start.
//  Throughput: 2+RD_LAT cycles per word once granted.
//  Grant loss: if m_grant=0 in RD, RD_WAIT or WR, abort the current word.
//    Go to REQ with m_wr=0. word_cnt is unchanged, so the same word is redone in full after re-grant.
//    A write is never counted unless m_grant=1 in WR.
//  start while busy: ignored. Latched parameters cannot change mid-job.
//  Mid-job reset: immediate return to IDLE. Outputs go to 0. The partially copied block is left as-is.
//  length=255 with src=0xF0: source addresses wrap 0xF0..0xFF,0x00..0xEE.
// TESTING
//  1. Slave0[0x01..0x04] = 1,2,3,4; start src=0x01 dst=0x21 len=4, m_grant tied 1
//     -> slave1[0x21..0x24] = 1..4. done pulses at cycle 2+4*3 after start. word_cnt=4.
//  2. len=0 start -> done pulses 1 cycle later. m_req never rises. busy high 1 cycle.
//  3. Other master holds the bus for 5 cycles -> m_req=1 stays in REQ with m_wr=0.
//     Copy completes correctly after grant.
//  4. Grant dropped in WR of word 2 of a 3-word copy -> word 2 is re-read and rewritten.
//     word_cnt never exceeds 3. Destination data is correct.
//  5. reset_n=0 asserted in RD_WAIT -> m_req, m_wr, busy and done are 0 asynchronously.
//     A new start after release copies correctly.
//  6. start pulsed again while busy, with different addresses -> ignored. Original job finishes unchanged.

Source files
------------

// File: rtl/bus_dma_master.sv
// Word-copy bus master: reads LENGTH words from SRC and writes them to DST, one word per
// read/write pair, over a shared arbitrated bus. All outputs decode from registered state.
module bus_dma_master #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  src_addr,
  input  logic [7:0]  dst_addr,
  input  logic [7:0]  length,
  input  logic        m_grant,
  input  logic [31:0] m_din,
  output logic        m_req,
  output logic        m_wr,
  output logic [7:0]  m_address,
  output logic [31:0] m_dout,
  output logic        busy,
  output logic        done,
  output logic [7:0]  word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_RD      = 3'd2,
    S_RD_WAIT = 3'd3,
    S_WR      = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  dst_q, dst_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  wait_q, wait_d;

  // State and job registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      src_q   <= 8'd0;
      dst_q   <= 8'd0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      data_q  <= 32'd0;
      wait_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; losing the grant anywhere in a word abandons that word
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != 8'd0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            len_d   = length;
            cnt_d   = 8'd0;
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (m_grant) begin
          state_d = S_RD;
        end else begin
          state_d = S_REQ;
        end
      end
      S_RD: begin
        if (!m_grant) begin
          state_d = S_REQ;
        end else begin
          wait_d  = 2'd0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (!m_grant) begin
          state_d = S_REQ;
        end else if (wait_q == 2'(RD_LAT - 1)) begin
          data_d  = m_din;
          state_d = S_WR;
        end else begin
          wait_d  = wait_q + 2'd1;
        end
      end
      S_WR: begin
        if (!m_grant) begin
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if ((cnt_q + 8'd1) == len_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode
  always_comb begin
    m_req     = 1'b0;
    m_wr      = 1'b0;
    m_address = 8'd0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_REQ: begin
        m_req = 1'b1;
      end
      S_RD, S_RD_WAIT: begin
        m_req     = 1'b1;
        m_address = src_q + cnt_q;
      end
      S_WR: begin
        m_req     = 1'b1;
        m_wr      = 1'b1;
        m_address = dst_q + cnt_q;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign m_dout   = data_q;
  assign word_cnt = cnt_q;

endmodule
